wb_stage_pipe: RTL

Parametrised MEM->WB pipeline stage. It carries the register-file write fields (we, waddr, wdata) and the full HI/LO write fields (whilo, hi, lo).
- Supersedes the fixed flop bank: adds a valid/ready handshake, an optional 2-entry skid buffer for registered backpressure, and a synchronous flush.
- Sits between the memory stage and the register-file/HI-LO write ports. Its outputs feed the regfile and the forwarding unit.

---
 rtl/cpu_pipe_pkg.sv | 23 ++
 rtl/pipe_skid2.sv | 114 +++++++++++
 rtl/wb_stage_pipe.sv | 57 +++++
 3 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: register-file/HI-LO widths, the writeback payload
// and the occupancy encoding used by the stage buffers.
package cpu_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] waddr;
    logic [XLEN-1:0]       wdata;
    logic                  whilo;
    logic [XLEN-1:0]       hi;
    logic [XLEN-1:0]       lo;
  } wb_payload_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/pipe_skid2.sv
// Generic width-W pipeline buffer: 2-entry skid with registered in_ready (SKID=1)
// or a single register with combinational in_ready (SKID=0). Flush empties it.
module pipe_skid2
  import cpu_pipe_pkg::*;
#(
  parameter int W    = 8,
  parameter int SKID = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  if (SKID != 0) begin : g_skid
    occ_t         state_reg, state_next;
    logic         ready_reg;
    logic [W-1:0] head_reg, skid_reg;
    logic         accept, pop;
    logic         load_head_in, load_head_skid, load_skid_in;

    assign accept = in_valid & ready_reg;
    assign pop    = (state_reg != OCC_EMPTY) & out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg <= OCC_EMPTY;
        ready_reg <= 1'b1;
      end else begin
        state_reg <= state_next;
        ready_reg <= (state_next != OCC_TWO);
      end
    end

    always_comb begin
      state_next = state_reg;
      if (flush) begin
        state_next = OCC_EMPTY;
      end else begin
        case (state_reg)
          OCC_EMPTY: if (accept) state_next = OCC_ONE;
          OCC_ONE: begin
            if (accept && !pop)      state_next = OCC_TWO;
            else if (pop && !accept) state_next = OCC_EMPTY;
          end
          OCC_TWO:   if (pop) state_next = OCC_ONE;
          default:   state_next = OCC_EMPTY;
        endcase
      end
    end

    // Slot load enables; flush suppresses every write so a killed entry never lands.
    always_comb begin
      load_head_in   = 1'b0;
      load_head_skid = 1'b0;
      load_skid_in   = 1'b0;
      if (!flush) begin
        case (state_reg)
          OCC_EMPTY: load_head_in = accept;
          OCC_ONE: begin
            load_head_in = accept & pop;
            load_skid_in = accept & ~pop;
          end
          OCC_TWO:   load_head_skid = pop;
          default:   load_head_in = 1'b0;
        endcase
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        head_reg <= '0;
        skid_reg <= '0;
      end else begin
        if (load_head_in)        head_reg <= in_data;
        else if (load_head_skid) head_reg <= skid_reg;
        if (load_skid_in)        skid_reg <= in_data;
      end
    end

    always_comb begin
      out_valid = (state_reg != OCC_EMPTY);
      in_ready  = ready_reg;
      out_data  = head_reg;
    end
  end else begin : g_single
    logic         valid_reg;
    logic [W-1:0] data_reg;
    logic         accept;

    assign in_ready  = out_ready | ~valid_reg;
    assign accept    = in_valid & in_ready;
    assign out_valid = valid_reg;
    assign out_data  = data_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        valid_reg <= 1'b0;
        data_reg  <= '0;
      end else begin
        if (flush)          valid_reg <= 1'b0;
        else if (accept)    valid_reg <= 1'b1;
        else if (out_ready) valid_reg <= 1'b0;
        if (!flush && accept) data_reg <= in_data;
      end
    end
  end

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM->WB stage: packs the regfile and HI/LO write fields into one buffered
// word and gates the write enables with the head-entry valid.
module wb_stage_pipe
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_wdata,
  input  logic              in_whilo,
  input  logic [DATA_W-1:0] in_hi,
  input  logic [DATA_W-1:0] in_lo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_we,
  output logic [ADDR_W-1:0] out_waddr,
  output logic [DATA_W-1:0] out_wdata,
  output logic              out_whilo,
  output logic [DATA_W-1:0] out_hi,
  output logic [DATA_W-1:0] out_lo
);

  localparam int W = 2 + ADDR_W + 3 * DATA_W;

  logic [W-1:0] in_data, head;
  logic         head_valid, head_we, head_whilo;

  assign in_data = {in_we, in_waddr, in_wdata, in_whilo, in_hi, in_lo};

  pipe_skid2 #(.W(W), .SKID(SKID)) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (head_valid),
    .out_ready (out_ready),
    .out_data  (head)
  );

  assign {head_we, out_waddr, out_wdata, head_whilo, out_hi, out_lo} = head;

  // Stale payload may linger after a pop or flush; only the enables must be killed.
  assign out_valid = head_valid;
  assign out_we    = head_we & head_valid;
  assign out_whilo = head_whilo & head_valid;

endmodule
